// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch/prefetch unit.
//   INSTR_W    instruction word width
//   PC_STEP    byte increment between sequential fetches
//   NOP_INSTR  canonical RISC-V nop (addi x0,x0,0)
//   fetch_entry_t  {pc, instr} pair as presented to decode (32-bit PC view)
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int ENTRY_PC_W = 32;
   typedef struct packed {
      logic [ENTRY_PC_W-1:0] pc;
      logic [INSTR_W-1:0]    instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and zeroed output when empty.
//   clk, rst    clock, synchronous active-high reset
//   flush       empties the FIFO; wins over push and pop in the same cycle
//   push/push_data  write an entry (dropped when full unless a pop frees a slot)
//   pop         advance the head (ignored when empty)
//   pop_data    head entry, all zeros when empty
//   count       current occupancy, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          empty, full, do_push, do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work too.
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty    = count == '0;
   assign full     = count == CW'(DEPTH);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= nxt(wr_ptr);
         if (do_pop)
            rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner issuing in-order IMEM requests into a prefetch FIFO feeding decode.
//   clk, rst                       clock, synchronous active-high reset
//   redirect_valid, redirect_pc    flush and restart fetch at redirect_pc (word aligned)
//   imem_req_valid/ready/addr      request channel, address held while stalled
//   imem_rsp_valid/data            in-order response channel
//   dec_valid/ready/instr/pc       decode handshake, head of the prefetch FIFO
//   fifo_count                     prefetch FIFO occupancy
//   perf_fetched, perf_stall       saturating counters, only with FETCH_PERF_CNT_EN defined
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              FIFO_DEPTH      = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic                          imem_req_valid,
   input  logic                          imem_req_ready,
   output logic [XLEN-1:0]               imem_req_addr,
   input  logic                          imem_rsp_valid,
   input  logic [INSTR_W-1:0]            imem_rsp_data,
   output logic                          dec_valid,
   input  logic                          dec_ready,
   output logic [INSTR_W-1:0]            dec_instr,
   output logic [XLEN-1:0]               dec_pc,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_fetched,
   output logic [31:0]                   perf_stall
`endif
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int EW = XLEN + INSTR_W;

   logic [XLEN-1:0] pc, pcq_head;
   logic [OW-1:0]   outstanding, drop_cnt;
   logic [QW-1:0]   pcq_count;
   logic [EW-1:0]   head;
   logic            req_fire, rsp_live, rsp_keep, fifo_push;

   // Credit rule: every outstanding request, even one that will be dropped,
   // reserves a FIFO slot, so the prefetch FIFO can never overflow.
   assign imem_req_valid = !rst && !redirect_valid
                           && (int'(outstanding) < MAX_OUTSTANDING)
                           && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // Responses with nothing outstanding belong to pre-reset traffic and are ignored.
   assign rsp_live       = imem_rsp_valid && outstanding != '0;
   // Stale responses (drop_cnt > 0) have no entry left in the PC queue.
   assign rsp_keep       = rsp_live && drop_cnt == '0 && pcq_count != '0;
   assign fifo_push      = rsp_keep && !redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(rsp_live);
         if (redirect_valid) begin
            pc       <= redirect_pc & ~XLEN'(3);
            drop_cnt <= outstanding - OW'(rsp_live);
         end else begin
            if (req_fire)
               pc <= pc + XLEN'(PC_STEP);
            if (rsp_live && drop_cnt != '0)
               drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

   fetch_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_prefetch (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data ({pcq_head, imem_rsp_data}),
      .pop       (dec_ready),
      .pop_data  (head),
      .count     (fifo_count)
   );

   // In-order record of request PCs, paired with responses as they return.
   fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (pc),
      .pop       (rsp_keep),
      .pop_data  (pcq_head),
      .count     (pcq_count)
   );

   assign dec_valid           = fifo_count != '0;
   assign {dec_pc, dec_instr} = head;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (dec_valid && dec_ready && perf_fetched != '1)
            perf_fetched <= perf_fetched + 32'd1;
         if (!dec_valid && dec_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: scoreboard bench for fetch_prefetch_unit with an in-order IMEM model.
module tb_fetch_prefetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        dec_valid, dec_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, dec_instr, dec_pc;
   logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   int checks = 0;
   int errors = 0;
   int hs     = 0;
   int cyc    = 0;
   int lat    = 1;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t        mq[$];
   fetch_entry_t exp_q[$];

   always #5 clk = ~clk;

   fetch_prefetch_unit #(
      .XLEN(32), .RESET_PC(32'h100), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .fifo_count     (fifo_count)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hA5C3_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_stream(input logic [31:0] base, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++)
         exp_q.push_back('{pc: base + 32'(4 * i), instr: instr_of(base + 32'(4 * i))});
   endtask

   task automatic phase_end(input string name);
      chk(name, 32'(hs > 0), 32'd1);
      hs = 0;
   endtask

   // IMEM model: accepts when ready, answers in order after lat cycles.
   initial begin
      mreq_t m;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready)
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
         @(posedge clk);
         cyc++;
         #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
               m = mq.pop_front();
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = instr_of(m.addr);
            end
         end
      end
   end

   // Monitor: every decode handshake is matched against the scoreboard.
   always @(negedge clk) begin
      fetch_entry_t e;
      if (!rst && !redirect_valid && dec_valid && dec_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dec_unexpected got pc %h expected no entry", dec_pc);
         end else begin
            e = exp_q.pop_front();
            chk("dec_pc", dec_pc, e.pc);
            chk("dec_instr", dec_instr, e.instr);
            hs++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  sum;
      bit  found;
      logic [31:0] a0;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; dec_ready = 1'b1;
      repeat (3) step();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);

      // Sequential fetch from RESET_PC, first decode two cycles after first request.
      push_stream(32'h100, 64);
      rst = 1'b0;
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h100);
      chk("lat_dec_valid_n", 32'(dec_valid), 32'd0);
      step();
      chk("second_req_addr", imem_req_addr, 32'h104);
      chk("lat_dec_valid_n1", 32'(dec_valid), 32'd0);
      step();
      chk("lat_dec_valid_n2", 32'(dec_valid), 32'd1);
      chk("lat_dec_pc_n2", dec_pc, 32'h100);
      repeat (8) step();

      // Decode backpressure: credit rule bounds outstanding + occupancy.
      dec_ready = 1'b0;
      repeat (20) begin
         step();
         sum = int'(fifo_count) + mq.size() + int'(imem_rsp_valid);
         chk("credit_bound", 32'(sum <= 4), 32'd1);
      end
      chk("stall_fifo_full", 32'(fifo_count), 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      dec_ready = 1'b1;
      repeat (10) step();
      phase_end("seq_progress");

      // Redirect with two outstanding and no response in the redirect cycle.
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = mq.size() == 2 && !imem_rsp_valid;
      end
      chk("redir1_found", 32'(found), 32'd1);
      push_stream(32'h2000, 64);
      redirect_valid = 1'b1; redirect_pc = 32'h2002;
      #1;
      chk("redir1_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("redir1_dec_valid", 32'(dec_valid), 32'd0);
      for (int i = 0; i < 20 && !imem_req_valid; i++) step();
      chk("redir1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir1_req_addr", imem_req_addr, 32'h2000);
      repeat (15) step();
      phase_end("redir1_progress");

      // Redirect colliding with a response and a decode pop.
      lat = 2;
      dec_ready = 1'b0;
      repeat (10) step();
      dec_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = imem_rsp_valid && dec_valid && (mq.size() + 1 == 2);
      end
      chk("redir2_found", 32'(found), 32'd1);
      push_stream(32'h3000, 64);
      redirect_valid = 1'b1; redirect_pc = 32'h3000;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("redir2_dec_valid", 32'(dec_valid), 32'd0);
      chk("redir2_fifo_count", 32'(fifo_count), 32'd0);
      repeat (15) step();
      phase_end("redir2_progress");

      // PC wrap at the top of the address space.
      lat = 1;
      push_stream(32'hFFFF_FFFC, 32);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      #1;
      for (int i = 0; i < 20 && !imem_req_valid; i++) step();
      chk("wrap_req_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
      step();
      for (int i = 0; i < 20 && !imem_req_valid; i++) step();
      chk("wrap_req_addr_lo", imem_req_addr, 32'h0000_0000);
      repeat (10) step();
      phase_end("wrap_progress");

      // IMEM stall holds the address; reset in mid-stall restarts cleanly.
      for (int i = 0; i < 20 && !imem_req_valid; i++) step();
      a0 = imem_req_addr;
      imem_req_ready = 1'b0;
      repeat (5) begin
         step();
         chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
         chk("hold_req_addr", imem_req_addr, a0);
      end
      rst = 1'b1;
      mq.delete();
      #1;
      chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      rst = 1'b0;
      imem_req_ready = 1'b1;
      push_stream(32'h100, 32);
      hs = 0;
      #1;
      chk("postrst_fifo_count", 32'(fifo_count), 32'd0);
      chk("postrst_dec_valid", 32'(dec_valid), 32'd0);
      chk("postrst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("postrst_req_addr", imem_req_addr, 32'h100);
      repeat (10) step();
      phase_end("postrst_progress");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parameterised successor to the single-register fetch stage.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel and a valid response channel.
- Buffers returned instructions, each paired with its PC, in a prefetch FIFO.
- Presents them to decode over a valid/ready handshake; flushes on redirect from a later stage and discards stale in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 0, PC value loaded on reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered IMEM requests; >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- redirect_valid  in  1  taken branch/jump from the later stage; flush and restart.
- redirect_pc  in  XLEN  new fetch PC.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  IMEM accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response valid; responses return in order.
- imem_rsp_data  in  32  instruction word.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode accepts.
- dec_instr  out  32  instruction.
- dec_pc  out  XLEN  PC of dec_instr.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset state:
  - PC = RESET_PC.
  - FIFO, outstanding counter and drop counter = 0.
  - imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, fifo_count=0.
  - rst asserted mid-operation discards everything in flight; responses after reset for pre-reset requests are not tracked (IMEM is reset by the same rst).
- Request issue:
  - imem_req_valid=1 when: !rst, !redirect_valid, outstanding < MAX_OUTSTANDING, and outstanding + fifo_count < FIFO_DEPTH (credit rule; the FIFO never overflows).
  - imem_req_addr = PC.
  - On valid&&ready: PC <= PC+4 (mod 2^XLEN, wraps), outstanding+1.
  - Address is held stable while valid&&!ready, except on redirect, which withdraws the request; IMEM tolerates withdrawal.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: drop_cnt-1 and the data is discarded.
  - Otherwise push {PC of request, data}. Request PCs are held in an internal MAX_OUTSTANDING-deep in-order PC queue.
- Decode side:
  - dec_valid = FIFO non-empty; dec_instr/dec_pc = head entry.
  - Pop on dec_valid&&dec_ready.
  - Simultaneous push and pop keeps count unchanged; push and pop both apply, including at count=FIFO_DEPTH-1 or when empty (no bypass: pushed entry is visible next cycle).
- Latency: with IMEM ready and a 1-cycle response, request at cycle N gives response at N+1 and dec_valid at N+2. First request is the first cycle after rst deasserts.
- Redirect (priority over everything):
  - PC <= {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO cleared (dec_valid=0 next cycle; a pop in the same cycle is ignored).
  - PC queue cleared.
  - drop_cnt <= outstanding − (response in this same cycle ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Requests to the new PC may issue while drop_cnt>0. Ordering guarantees the old responses are dropped first.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0].
  - perf_fetched counts decode handshakes.
  - perf_stall counts cycles with dec_ready=1 && dec_valid=0.
  - Both reset to 0 on rst and saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h00000013.
  - Struct fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with flush, count, push/pop. It is used for both the prefetch FIFO and the PC queue.

Test Plan:
- Reset release, RESET_PC=0x100, IMEM always ready, 1-cycle response, dec_ready=1 -> requests 0x100, 0x104, 0x108…; dec_pc sequence 0x100, 0x104… with first dec_valid 2 cycles after the first request.
- dec_ready=0 for 20 cycles -> fifo_count saturates at 4; outstanding+count never exceeds 4; imem_req_valid drops; no data lost when dec_ready returns.
- Redirect to 0x2002 with 2 outstanding -> next request addr 0x2000; both stale responses dropped; first dec_pc=0x2000.
- Redirect in the same cycle as a response and a pop -> response discarded; FIFO empty next cycle; drop_cnt=outstanding−1.
- PC=0xFFFFFFFC with XLEN=32 -> next request addr 0x00000000.
- imem_req_ready=0 for 5 cycles -> addr stable; rst asserted mid-stall -> next cycle imem_req_valid=0, fifo_count=0, PC=RESET_PC.
